// File: rtl/lab3_pkg.sv
// -----------------------------------------------------------------------------
// lab3_pkg
//   Shared constants and helpers for the value stepper that feeds the
//   binary-to-two-digit decimal HEX display stage.
//   - VAL_W / VAL_MAX     : width and largest value of the displayed number
//   - DB_CYCLES_DEF       : default debounce length (10 ms at 50 MHz)
//   - AUTO_DIV_DEF        : default auto-increment divider (1 Hz at 50 MHz)
//   - CLK_HZ              : board clock frequency
//   - step_res_t/step_val : one wrap-around step of the value
// -----------------------------------------------------------------------------
package lab3_pkg;

  localparam int VAL_W         = 4;
  localparam int CLK_HZ        = 50_000_000;
  localparam int DB_CYCLES_DEF = 500_000;
  localparam int AUTO_DIV_DEF  = 50_000_000;

  typedef logic [VAL_W-1:0] val_t;

  localparam val_t VAL_MAX  = 4'd15;
  localparam val_t VAL_ZERO = 4'd0;
  localparam val_t VAL_ONE  = 4'd1;

  // Result of a single step: the new value and whether it crossed the wrap point.
  typedef struct packed {
    logic wrap;
    val_t val;
  } step_res_t;

  // One step up or down with modulo-16 wrap; wrap flags 15->0 and 0->15.
  function automatic step_res_t step_val(input val_t cur, input logic down);
    step_res_t res;
    if (down) begin
      res.val  = cur - VAL_ONE;
      res.wrap = (cur == VAL_ZERO);
    end else begin
      res.val  = cur + VAL_ONE;
      res.wrap = (cur == VAL_MAX);
    end
    return res;
  endfunction

endpackage

// File: rtl/value_stepper_if.sv
// -----------------------------------------------------------------------------
// value_stepper_if
//   Bundles the board-facing inputs and display-facing outputs of the value
//   stepper.
//   key_up_n/key_dn_n/key_ld_n : raw active-low pushbuttons (asynchronous)
//   sw_val                     : load value from switches
//   auto_en                    : auto-increment slide switch (asynchronous)
//   v                          : current value to the display decoder
//   step_pulse                 : 1-cycle pulse on every write of v
//   wrap                       : 1-cycle pulse when a step crosses 15<->0
//   modport master : the board / stimulus side
//   modport slave  : the value stepper itself
// -----------------------------------------------------------------------------
interface value_stepper_if;
  import lab3_pkg::*;

  logic key_up_n;
  logic key_dn_n;
  logic key_ld_n;
  val_t sw_val;
  logic auto_en;
  val_t v;
  logic step_pulse;
  logic wrap;

  modport master (
    output key_up_n, key_dn_n, key_ld_n, sw_val, auto_en,
    input  v, step_pulse, wrap
  );

  modport slave (
    input  key_up_n, key_dn_n, key_ld_n, sw_val, auto_en,
    output v, step_pulse, wrap
  );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Synchronizes one raw active-low pushbutton, debounces it and produces a
//   single-cycle press pulse on the released->pressed transition of the
//   debounced state. Release produces nothing; a held key yields one press.
//   Ports:
//     clk    : system clock
//     rst_n  : asynchronous active-low reset
//     key_n  : raw pushbutton, active-low, asynchronous
//     press  : 1-cycle pulse on debounced 1->0 edge
//   A level change is accepted after the synchronized level has differed from
//   the debounced state for DB_CYCLES consecutive cycles; any cycle where they
//   agree restarts the count.
// -----------------------------------------------------------------------------
module key_debounce
  import lab3_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             db_r;
  logic             db_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter and accepted state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_ZERO;
      db_r  <= 1'b1;
    end else if (sync2_r == db_r) begin
      cnt_r <= CNT_ZERO;
      db_r  <= db_r;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= CNT_ZERO;
      db_r  <= sync2_r;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      db_r  <= db_r;
    end
  end

  // One-cycle delayed copy of the debounced state for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_d_r <= 1'b1;
    end else begin
      db_d_r <= db_r;
    end
  end

  // Press is the 1->0 edge of the debounced (active-low) state.
  assign press = db_d_r & ~db_r;

endmodule

// File: rtl/value_stepper.sv
// -----------------------------------------------------------------------------
// value_stepper
//   Produces the 4-bit value shown on the two-digit decimal HEX display.
//   Debounced keys step the value up/down with wrap-around or load it from the
//   switches; with auto_en set the value also increments once every AUTO_DIV
//   cycles.
//   Ports:
//     clk    : system clock (50 MHz)
//     rst_n  : asynchronous active-low reset
//     bus    : value_stepper_if.slave (keys, switches, auto_en in;
//              v, step_pulse, wrap out)
//   Update priority within one cycle: load > (up XOR down) > auto tick.
//   Simultaneous up and down cancel each other and also swallow a tick; a tick
//   that collides with any key event is dropped rather than deferred.
//   No clamping: values above 9 are split by the downstream decoder.
// -----------------------------------------------------------------------------
module value_stepper
  import lab3_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int AUTO_DIV  = AUTO_DIV_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  value_stepper_if.slave bus
);

  localparam int PRESC_W = (AUTO_DIV > 2) ? $clog2(AUTO_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_ZERO = '0;
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(AUTO_DIV - 1);

  logic               up_press_s;
  logic               dn_press_s;
  logic               ld_press_s;
  logic               auto_sync1_r;
  logic               auto_sync2_r;
  logic [PRESC_W-1:0] presc_r;
  logic               tick_s;
  step_res_t          step_s;
  val_t               v_nxt_s;
  logic               we_s;
  logic               wrap_nxt_s;
  val_t               v_r;
  logic               step_pulse_r;
  logic               wrap_r;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_up (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_up_n),
    .press (up_press_s)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_dn (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_dn_n),
    .press (dn_press_s)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_ld (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_ld_n),
    .press (ld_press_s)
  );

  // Two-flop synchronizer for the auto-increment switch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_sync1_r <= 1'b0;
      auto_sync2_r <= 1'b0;
    end else begin
      auto_sync1_r <= bus.auto_en;
      auto_sync2_r <= auto_sync1_r;
    end
  end

  // The tick is asserted during the cycle the prescaler sits at its last count.
  assign tick_s = auto_sync2_r & (presc_r == PRESC_LAST);

  // Prescaler: counts 0..AUTO_DIV-1 while auto mode is on, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= PRESC_ZERO;
    end else if (!auto_sync2_r) begin
      presc_r <= PRESC_ZERO;
    end else if (tick_s) begin
      presc_r <= PRESC_ZERO;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  // Direction for the single-step path: down only when down alone was pressed.
  assign step_s = step_val(v_r, dn_press_s & ~up_press_s);

  // Priority mux selecting the next value and its pulses.
  always_comb begin
    v_nxt_s    = v_r;
    we_s       = 1'b0;
    wrap_nxt_s = 1'b0;
    if (ld_press_s) begin
      v_nxt_s    = bus.sw_val;
      we_s       = 1'b1;
      wrap_nxt_s = 1'b0;
    end else if (up_press_s ^ dn_press_s) begin
      v_nxt_s    = step_s.val;
      we_s       = 1'b1;
      wrap_nxt_s = step_s.wrap;
    end else if (up_press_s & dn_press_s) begin
      // Opposing presses cancel; a coincident tick is swallowed too.
      v_nxt_s    = v_r;
      we_s       = 1'b0;
      wrap_nxt_s = 1'b0;
    end else if (tick_s) begin
      // No key event here, so step_s is the increment.
      v_nxt_s    = step_s.val;
      we_s       = 1'b1;
      wrap_nxt_s = step_s.wrap;
    end else begin
      v_nxt_s    = v_r;
      we_s       = 1'b0;
      wrap_nxt_s = 1'b0;
    end
  end

  // Output registers: value plus the one-cycle write and wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r          <= VAL_ZERO;
      step_pulse_r <= 1'b0;
      wrap_r       <= 1'b0;
    end else begin
      v_r          <= v_nxt_s;
      step_pulse_r <= we_s;
      wrap_r       <= wrap_nxt_s;
    end
  end

  assign bus.v          = v_r;
  assign bus.step_pulse = step_pulse_r;
  assign bus.wrap       = wrap_r;

endmodule

// File: tb/tb_value_stepper.sv
// -----------------------------------------------------------------------------
// tb_value_stepper
//   Directed bench for value_stepper with DB_CYCLES=4, AUTO_DIV=8. Stimulus
//   pushes the expected (v, wrap, cycle) of every step into a queue; a monitor
//   pops and compares whenever step_pulse is seen. Key events land on edge 7
//   after the first edge sampling a stable low key.
// -----------------------------------------------------------------------------
module tb_value_stepper;
  import lab3_pkg::*;

  typedef struct {
    logic [3:0] v;
    logic       wrap;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  value_stepper_if bus ();

  value_stepper #(.DB_CYCLES(4), .AUTO_DIV(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every step pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.step_pulse === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_step: cyc=%0d v=%0d wrap=%0d, required no step", cyc, bus.v, bus.wrap);
      end else begin
        e = sb_q.pop_front();
        if (bus.v !== e.v || bus.wrap !== e.wrap || cyc != e.cyc)
          begin
            n_err++;
            $display("FAIL step: got v=%0d wrap=%0d cyc=%0d, required v=%0d wrap=%0d cyc=%0d",
                     bus.v, bus.wrap, cyc, e.v, e.wrap, e.cyc);
          end
      end
    end else if (rst_n === 1'b1 && bus.wrap !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL stray_wrap: cyc=%0d wrap=%0d without step_pulse, required 0", cyc, bus.wrap);
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_step(input logic [3:0] v, input logic w, input int at);
    exp_t e;
    e.v    = v;
    e.wrap = w;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  // Press a set of keys together for 12 cycles, then release and let it settle.
  task automatic press(input bit up, input bit dn, input bit ld,
                       input bit has_exp, input logic [3:0] ev, input logic ew);
    @(negedge clk);
    if (has_exp) expect_step(ev, ew, cyc + 7);
    bus.key_up_n = ~up;
    bus.key_dn_n = ~dn;
    bus.key_ld_n = ~ld;
    tick_n(12);
    bus.key_up_n = 1'b1;
    bus.key_dn_n = 1'b1;
    bus.key_ld_n = 1'b1;
    tick_n(10);
  endtask

  initial begin
    int n0;
    n_vec = 0;
    n_err = 0;

    // 1. Reset with keys low and auto_en high; release with up still held.
    rst_n        = 1'b0;
    bus.key_up_n = 1'b0;
    bus.key_dn_n = 1'b0;
    bus.key_ld_n = 1'b0;
    bus.sw_val   = 4'd0;
    bus.auto_en  = 1'b1;
    tick_n(4);
    check("rst_v", int'(bus.v), 0);
    check("rst_step", int'(bus.step_pulse), 0);
    check("rst_wrap", int'(bus.wrap), 0);
    check("rst_presc", int'(dut.presc_r), 0);
    bus.key_dn_n = 1'b1;
    bus.key_ld_n = 1'b1;
    bus.auto_en  = 1'b0;
    tick_n(2);
    expect_step(4'd1, 1'b0, cyc + 7);
    rst_n = 1'b1;
    tick_n(20);
    bus.key_up_n = 1'b1;
    tick_n(10);
    check("held_through_reset_v", int'(bus.v), 1);

    // 2. Bouncing up key, then stable low: a single increment, none on release.
    bus.key_up_n = 1'b0; tick_n(1);
    bus.key_up_n = 1'b1; tick_n(1);
    bus.key_up_n = 1'b0; tick_n(1);
    bus.key_up_n = 1'b1; tick_n(1);
    expect_step(4'd2, 1'b0, cyc + 7);
    bus.key_up_n = 1'b0;
    tick_n(20);
    bus.key_up_n = 1'b1;
    tick_n(12);
    check("bounce_v", int'(bus.v), 2);

    // 3. Wrap in both directions.
    bus.sw_val = 4'd15;
    press(1'b0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b1);
    press(1'b0, 1'b1, 1'b0, 1'b1, 4'd14, 1'b0);

    // 4. Up+down cancel; load beats up.
    press(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check("cancel_v", int'(bus.v), 14);
    bus.sw_val = 4'd12;
    press(1'b1, 1'b0, 1'b1, 1'b1, 4'd12, 1'b0);

    // 5. Auto increment: 16 ticks back to 0, key event on a tick, then freeze.
    bus.sw_val = 4'd0;
    press(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    @(negedge clk);
    n0 = cyc;
    for (int k = 1; k <= 16; k++)
      expect_step(4'(k), (k == 16), n0 + 2 + 8 * k);
    bus.auto_en = 1'b1;
    for (int g = 0; g < 200 && cyc < n0 + 131; g++) @(negedge clk);
    check("align_cyc", cyc, n0 + 131);
    expect_step(4'd1, 1'b0, n0 + 138);
    bus.key_up_n = 1'b0;
    tick_n(8);
    bus.auto_en = 1'b0;
    tick_n(6);
    bus.key_up_n = 1'b1;
    tick_n(10);
    check("auto_off_presc", int'(dut.presc_r), 0);
    tick_n(30);
    check("auto_off_v", int'(bus.v), 1);

    // 6. Async reset mid-debounce and between steps.
    bus.key_up_n = 1'b0;
    tick_n(3);
    check("mid_db_cnt", int'(dut.u_key_up.cnt_r), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst6_v", int'(bus.v), 0);
    check("rst6_step", int'(bus.step_pulse), 0);
    check("rst6_wrap", int'(bus.wrap), 0);
    check("rst6_cnt", int'(dut.u_key_up.cnt_r), 0);
    check("rst6_presc", int'(dut.presc_r), 0);
    bus.key_up_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick_n(12);
    check("post_rst6_v", int'(bus.v), 0);
    bus.sw_val = 4'd9;
    press(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst6b_v", int'(bus.v), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_n(5);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_step: got no step, required v=%0d wrap=%0d at cyc=%0d", e.v, e.wrap, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
